// File: rtl/pcode_pkg.sv
// Shared code-generator definitions: default widths, code length and FSM encoding.
// Used by pcode_addr_gen, pcode_phase_acc and pcode_rom.
package pcode_pkg;

  localparam int unsigned ACC_W    = 32;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned CODE_LEN = 40960;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pcode_state_e;

endpackage

// File: rtl/pcode_phase_acc.sv
// Code-phase accumulator: adds fcw each advance cycle; tick is the carry out of the MSB.
// tick is combinational so the address counter steps on the same edge the accumulator wraps.
module pcode_phase_acc #(
  parameter int unsigned ACC_W = pcode_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [ACC_W-1:0] fcw,
  output logic             tick
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   sum_c;

  assign sum_c = {1'b0, acc_q} + {1'b0, fcw};
  assign tick  = adv & ~clr & sum_c[ACC_W];

  // Phase register: clear on load, accumulate when advancing, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (adv) begin
      acc_q <= sum_c[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/pcode_addr_gen.sv
// Code-phase NCO: steps pcode_addr at the programmed chip rate, wraps at CODE_LEN, and
// realigns the registered ROM lanes into chip/chip_valid/epoch two cycles after each
// address update.
// Optional build macro PCODE_EPOCH_CNT_EN adds epoch_cnt[15:0] (epoch pulse counter).
module pcode_addr_gen #(
  parameter int unsigned ACC_W    = pcode_pkg::ACC_W,
  parameter int unsigned ADDR_W   = pcode_pkg::ADDR_W,
  parameter int unsigned CODE_LEN = pcode_pkg::CODE_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              stop,
  input  logic [ACC_W-1:0]  fcw,
  output logic [ADDR_W-1:0] pcode_addr,
  input  logic              pcode_0,
  input  logic              pcode_1,
  input  logic              pcode_2,
  input  logic              pcode_3,
  input  logic              pcode_4,
  input  logic              pcode_5,
  input  logic              pcode_6,
  input  logic              pcode_7,
  output logic [7:0]        chip,
  output logic              chip_valid,
  output logic              epoch,
`ifdef PCODE_EPOCH_CNT_EN
  output logic [15:0]       epoch_cnt,
`endif
  output logic              running
);

  import pcode_pkg::*;

  pcode_state_e state_q, state_d;
  logic         load_go_c;
  logic         adv_c;
  logic         tick;
  logic         nf0_q, nf1_q;
  logic         zero1_q;

  // Next state: stop beats load; load restarts from either state; advance only in RUN
  always_comb begin
    state_d   = state_q;
    load_go_c = 1'b0;
    adv_c     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (load) begin
      state_d   = RUN;
      load_go_c = 1'b1;
    end else if (state_q == RUN && en) begin
      adv_c = 1'b1;
    end
  end

  // State register and registered running flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
    end
  end

  pcode_phase_acc #(
    .ACC_W (ACC_W)
  ) u_phase_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_go_c),
    .adv  (adv_c),
    .fcw  (fcw),
    .tick (tick)
  );

  // Address counter: out-of-range load addresses start at chip 0
  always_ff @(posedge clk) begin
    if (rst) begin
      pcode_addr <= '0;
    end else if (load_go_c) begin
      pcode_addr <= (32'(load_addr) >= 32'(CODE_LEN)) ? '0 : load_addr;
    end else if (tick) begin
      pcode_addr <= (pcode_addr == ADDR_W'(CODE_LEN - 1)) ? '0 : pcode_addr + ADDR_W'(1);
    end
  end

  // Alignment pipeline: nf0 marks a fresh address, nf1 marks ROM data valid for it
  always_ff @(posedge clk) begin
    if (rst) begin
      nf0_q      <= 1'b0;
      nf1_q      <= 1'b0;
      zero1_q    <= 1'b0;
      chip       <= '0;
      chip_valid <= 1'b0;
      epoch      <= 1'b0;
    end else begin
      nf0_q      <= load_go_c | tick;
      nf1_q      <= nf0_q;
      zero1_q    <= (pcode_addr == '0);
      chip_valid <= nf1_q;
      epoch      <= nf1_q & zero1_q;
      if (nf1_q) begin
        chip <= {pcode_7, pcode_6, pcode_5, pcode_4, pcode_3, pcode_2, pcode_1, pcode_0};
      end
    end
  end

`ifdef PCODE_EPOCH_CNT_EN
  // Epoch counter: cleared by an accepted load, counts alongside the epoch strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_cnt <= '0;
    end else if (load_go_c) begin
      epoch_cnt <= '0;
    end else if (nf1_q & zero1_q) begin
      epoch_cnt <= epoch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcode_addr_gen.sv
// Bench for pcode_addr_gen with a behavioural registered 8-lane ROM.
// Set PCODE_EPOCH_CNT_EN to also exercise epoch_cnt.
module tb_pcode_addr_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] load_addr;
  logic        stop;
  logic [31:0] fcw;
  logic [15:0] pcode_addr;
  logic [7:0]  rom_q;
  logic [7:0]  chip;
  logic        chip_valid;
  logic        epoch;
  logic        running;
`ifdef PCODE_EPOCH_CNT_EN
  logic [15:0] epoch_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  pcode_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_addr  (load_addr),
    .stop       (stop),
    .fcw        (fcw),
    .pcode_addr (pcode_addr),
    .pcode_0    (rom_q[0]),
    .pcode_1    (rom_q[1]),
    .pcode_2    (rom_q[2]),
    .pcode_3    (rom_q[3]),
    .pcode_4    (rom_q[4]),
    .pcode_5    (rom_q[5]),
    .pcode_6    (rom_q[6]),
    .pcode_7    (rom_q[7]),
    .chip       (chip),
    .chip_valid (chip_valid),
    .epoch      (epoch),
`ifdef PCODE_EPOCH_CNT_EN
    .epoch_cnt  (epoch_cnt),
`endif
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known ROM contents: distinct per-address byte
  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return 8'(lo * 8'd29) ^ a[15:8] ^ 8'hA5;
  endfunction

  // Registered ROM: data valid one cycle after the address is sampled
  always @(posedge clk) rom_q <= mem(pcode_addr);

  typedef struct packed {
    logic [15:0]      load_addr;
    logic [31:0]      fcw;
    logic [3:0][15:0] exp_addr;
    logic [3:0][7:0]  exp_t;
    logic [3:0]       exp_ep;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input logic [15:0] la, input logic [31:0] f,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [7:0] t0, input logic [7:0] t1,
                              input logic [7:0] t2, input logic [7:0] t3,
                              input logic [3:0] ep);
    vec_t r;
    r.load_addr   = la;
    r.fcw         = f;
    r.exp_addr[0] = a0; r.exp_addr[1] = a1; r.exp_addr[2] = a2; r.exp_addr[3] = a3;
    r.exp_t[0]    = t0; r.exp_t[1]    = t1; r.exp_t[2]    = t2; r.exp_t[3]    = t3;
    r.exp_ep      = ep;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; load = 1'b0; stop = 1'b0; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accepted load; returns at the negedge after the load edge
  task automatic do_load(input logic [15:0] a, input logic [31:0] f);
    @(negedge clk);
    load = 1'b1; load_addr = a; fcw = f; en = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (bounded) until pcode_addr shows target just after an edge
  task automatic wait_addr(input logic [15:0] target, input string nm);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (pcode_addr == target) found = 1'b1;
    end
    check(nm, 32'(found), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int k;
    int strobes;
    bit got;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_addr = '0; stop = 1'b0; fcw = '0;

    vecs[0] = mk(16'd5,     32'h8000_0000, 16'd5,     16'd6,     16'd7, 16'd8,
                 8'd2, 8'd4, 8'd6, 8'd8,   4'b0000);
    vecs[1] = mk(16'd40958, 32'hFFFF_FFFF, 16'd40958, 16'd40959, 16'd0, 16'd1,
                 8'd2, 8'd4, 8'd5, 8'd6,   4'b0100);
    vecs[2] = mk(16'd50000, 32'h8000_0000, 16'd0,     16'd1,     16'd2, 16'd3,
                 8'd2, 8'd4, 8'd6, 8'd8,   4'b0001);
    vecs[3] = mk(16'd100,   32'h4000_0000, 16'd100,   16'd101,   16'd102, 16'd103,
                 8'd2, 8'd6, 8'd10, 8'd14, 4'b0000);
    vecs[4] = mk(16'd40959, 32'hFFFF_FFFF, 16'd40959, 16'd0,     16'd1, 16'd2,
                 8'd2, 8'd4, 8'd5, 8'd6,   4'b0010);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(pcode_addr), 32'd0);
    check("rst_chip", 32'(chip), 32'd0);
    check("rst_valid", 32'(chip_valid), 32'd0);
    check("rst_epoch", 32'(epoch), 32'd0);
    check("rst_running", 32'(running), 32'd0);
`ifdef PCODE_EPOCH_CNT_EN
    check("rst_epoch_cnt", 32'(epoch_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Table: load, then first four chips with timing relative to the load edge
    for (int v = 0; v < 5; v++) begin
      do_reset();
      @(negedge clk);
      load = 1'b1; load_addr = vecs[v].load_addr; fcw = vecs[v].fcw; en = 1'b1;
      @(posedge clk); #1;
      check($sformatf("v%0d_load_addr", v), 32'(pcode_addr), 32'(vecs[v].exp_addr[0]));
      check($sformatf("v%0d_running", v), 32'(running), 32'd1);
      @(negedge clk);
      load = 1'b0;
      k = 0;
      for (int c = 1; c <= 24 && k < 4; c++) begin
        @(posedge clk); #1;
        check($sformatf("v%0d_epoch_gated", v), 32'(epoch & ~chip_valid), 32'd0);
        if (chip_valid) begin
          check($sformatf("v%0d_s%0d_time", v, k), 32'(c), 32'(vecs[v].exp_t[k]));
          check($sformatf("v%0d_s%0d_chip", v, k), 32'(chip),
                32'(mem(vecs[v].exp_addr[k])));
          check($sformatf("v%0d_s%0d_epoch", v, k), 32'(epoch), 32'(vecs[v].exp_ep[k]));
          k++;
        end
      end
      check($sformatf("v%0d_strobes", v), 32'(k), 32'd4);
    end

    // en low for 10 cycles: address frozen, only the in-flight chip appears
    do_reset();
    do_load(16'd5, 32'h8000_0000);
    wait_addr(16'd7, "en_reach7");
    @(negedge clk);
    en = 1'b0;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("en_hold_addr", 32'(pcode_addr), 32'd7);
      if (chip_valid) begin
        strobes++;
        check("en_inflight_chip", 32'(chip), 32'(mem(16'd7)));
      end
    end
    check("en_pause_strobes", 32'(strobes), 32'd1);
    @(negedge clk);
    en = 1'b1;
    for (int n = 8; n <= 9; n++) begin
      got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
        @(posedge clk); #1;
        if (chip_valid) begin
          got = 1'b1;
          check($sformatf("en_resume_chip%0d", n), 32'(chip), 32'(mem(16'(n))));
        end
      end
      check($sformatf("en_resume_seen%0d", n), 32'(got), 32'd1);
    end

    // stop + load together: stop wins, in-flight chip still delivered, then silence
    do_reset();
    do_load(16'd5, 32'h8000_0000);
    wait_addr(16'd6, "stop_reach6");
    @(negedge clk);
    stop = 1'b1; load = 1'b1; load_addr = 16'd300;
    @(posedge clk); #1;
    check("stop_running", 32'(running), 32'd0);
    check("stop_addr_kept", 32'(pcode_addr), 32'd6);
    @(negedge clk);
    stop = 1'b0; load = 1'b0;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (chip_valid) begin
        strobes++;
        check("stop_last_chip", 32'(chip), 32'(mem(16'd6)));
      end
    end
    check("stop_strobes", 32'(strobes), 32'd1);
    check("stop_addr_idle", 32'(pcode_addr), 32'd6);

    // Reset one cycle after an address update discards the in-flight chip
    do_reset();
    do_load(16'd5, 32'h8000_0000);
    wait_addr(16'd6, "rst_reach6");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 32'(chip_valid), 32'd0);
    check("midrst_chip", 32'(chip), 32'd0);
    check("midrst_epoch", 32'(epoch), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_addr", 32'(pcode_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (chip_valid) strobes++;
    end
    check("midrst_strobes", 32'(strobes), 32'd0);

`ifdef PCODE_EPOCH_CNT_EN
    // Epoch counter: one epoch after an out-of-range load, cleared by reload
    do_reset();
    do_load(16'd50000, 32'h8000_0000);
    repeat (6) @(posedge clk);
    #1;
    check("ecnt_after_epoch", 32'(epoch_cnt), 32'd1);
    do_load(16'd10, 32'h8000_0000);
    check("ecnt_after_reload", 32'(epoch_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
